// File: rtl/mux_nto1_rr.sv
// rtl/mux_nto1_rr.sv - registered N:1 valid/ready mux with fixed-select and round-robin modes
module mux_nto1_rr #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SELW  = $clog2(CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*WIDTH-1:0]   in_data,
  input  logic [CH-1:0]         in_valid,
  output logic [CH-1:0]         in_ready,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_ch
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  rr_idx;
  logic [WIDTH-1:0] gnt_data;

  assign load = !out_valid_q || out_ready;

  // Round-robin scan starts just after the last-served channel, so it ranks lowest.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    if (!mode) begin
      for (int i = 0; i < CH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end else begin
      for (int off = 1; off <= CH; off++) begin
        rr_idx = SELW'((int'(ptr_q) + off) % CH);
        if (!gnt_vld && in_valid[rr_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < CH; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = rst_n && load && gnt_vld;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gnt_vld) begin
        out_data_d  = gnt_data;
        out_valid_d = 1'b1;
        out_ch_d    = gnt_idx;
        ptr_d       = gnt_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= SELW'(CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb/tb_mux_nto1_rr.sv - scoreboard bench for mux_nto1_rr, default plus CH=3/WIDTH=1 and CH=16/WIDTH=64
module tb_mux_nto1_rr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic        mode, out_valid, out_ready;
  logic [1:0]  sel, out_ch;
  logic [7:0]  out_data;

  logic [2:0]  d3_in_data, d3_in_valid, d3_in_ready;
  logic        d3_mode, d3_out_valid, d3_out_ready;
  logic [1:0]  d3_sel, d3_out_ch;
  logic [0:0]  d3_out_data;

  logic [1023:0] d16_in_data;
  logic [15:0]   d16_in_valid, d16_in_ready;
  logic          d16_mode, d16_out_valid, d16_out_ready;
  logic [3:0]    d16_sel, d16_out_ch;
  logic [63:0]   d16_out_data;

  mux_nto1_rr #(.WIDTH(8), .CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch));

  mux_nto1_rr #(.WIDTH(1), .CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .mode(d3_mode), .sel(d3_sel), .out_data(d3_out_data), .out_valid(d3_out_valid),
    .out_ready(d3_out_ready), .out_ch(d3_out_ch));

  mux_nto1_rr #(.WIDTH(64), .CH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_data(d16_in_data), .in_valid(d16_in_valid),
    .in_ready(d16_in_ready), .mode(d16_mode), .sel(d16_sel), .out_data(d16_out_data),
    .out_valid(d16_out_valid), .out_ready(d16_out_ready), .out_ch(d16_out_ch));

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] c);
    exp_q.push_back({c, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output words leaving the register are popped against the expected queue.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ch=%0d data=%0h expected nothing", out_ch, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_ch, out_data} !== e) begin
          errors++;
          $display("FAIL sb_word: got ch=%0d data=%0h expected ch=%0d data=%0h",
                   out_ch, out_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  localparam logic [63:0] BASE64 = 64'h0123_4567_89AB_CDE0;
  localparam logic [1:0]  RR3_CH [4]  = '{2'd0, 2'd1, 2'd2, 2'd0};
  localparam logic        RR3_BIT[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic [3:0]  RR16_CH[3]  = '{4'd0, 4'd15, 4'd0};

  initial begin
    rst_n = 1'b0;
    in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    in_valid = 4'hF; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    d3_in_data = 3'b101; d3_in_valid = '0; d3_mode = 1'b0; d3_sel = '0; d3_out_ready = 1'b1;
    d16_in_valid = '0; d16_mode = 1'b0; d16_sel = '0; d16_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) d16_in_data[i*64 +: 64] = BASE64 + 64'(i);

    repeat (2) tick();
    chk("rst_in_ready", in_ready, 4'b0000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    rst_n = 1'b1;
    #1;
    chk("rr_first_grant", in_ready, 4'b0001);

    for (int k = 0; k < 8; k++) push(8'hA0 + 8'h11 * 8'(k % 4), 2'(k % 4));
    repeat (8) tick();
    in_valid = 4'b1010;
    push(8'hB1, 1); push(8'hD3, 3); push(8'hB1, 1); push(8'hD3, 3);
    repeat (4) tick();

    mode = 1'b0; sel = 2'd2; in_valid = 4'hF;
    in_data = {8'hD3, 8'hA5, 8'hB1, 8'hA0};
    #1;
    chk("fix_in_ready", in_ready, 4'b0100);
    push(8'hA5, 2);
    tick();
    sel = 2'd3; in_valid = 4'b0111;
    #1;
    chk("fix_no_grant_ready", in_ready, 4'b0000);
    tick();
    chk("fix_valid_drop", out_valid, 0);

    sel = 2'd0; in_valid = 4'hF;
    in_data = {8'hD3, 8'hA5, 8'hB1, 8'h11};
    push(8'h11, 0);
    tick();
    out_ready = 1'b0;
    in_data = {8'hD3, 8'hA5, 8'hB1, 8'h22};
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", in_ready, 4'b0000);
      chk("bp_out_data", out_data, 8'h11);
      chk("bp_out_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 4'b0001);
    push(8'h22, 0);
    tick();
    chk("bp_nogap_data", out_data, 8'h22);
    chk("bp_nogap_valid", out_valid, 1);
    in_valid = 4'h0;
    tick();

    in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    mode = 1'b1; in_valid = 4'b0100;
    push(8'hC2, 2);
    tick();
    mode = 1'b0; sel = 2'd0; in_valid = 4'hF;
    push(8'hA0, 0); push(8'hA0, 0);
    repeat (2) tick();
    mode = 1'b1;
    #1;
    chk("modesw_grant", in_ready, 4'b0010);
    push(8'hB1, 1);
    tick();
    in_valid = 4'h0;
    tick();

    out_ready = 1'b0; in_valid = 4'hF; mode = 1'b1;
    tick();
    chk("midrst_loaded", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_ch", out_ch, 0);
    chk("midrst_in_ready", in_ready, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("postrst_grant", in_ready, 4'b0001);
    push(8'hA0, 0);
    tick();
    in_valid = 4'h0;
    repeat (2) tick();
    chk("sb_drained", exp_q.size(), 0);

    d3_mode = 1'b1; d3_in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ch3_rr_ch", d3_out_ch, RR3_CH[k]);
      chk("ch3_rr_data", d3_out_data, RR3_BIT[k]);
    end
    d3_mode = 1'b0; d3_sel = 2'd3;
    #1;
    chk("ch3_sel_oob_ready", d3_in_ready, 3'b000);
    tick();
    chk("ch3_sel_oob_valid", d3_out_valid, 0);

    d16_mode = 1'b1; d16_in_valid = 16'h8001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ch16_rr_ch", d16_out_ch, RR16_CH[k]);
      chk("ch16_rr_data", d16_out_data, BASE64 + 64'(RR16_CH[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
